// File: rtl/config_loader.sv
// Configuration master: unpacks a framed word stream (header, then N
// address/data pairs) into single-cycle config_addr/config_data write pulses.
// Between pulses the address bus is parked on IDLE_ADDR, which no tile decodes.
module config_loader #(
  parameter logic [31:0] IDLE_ADDR = 32'hFFFF_FFFF,
  parameter logic [15:0] MAGIC     = 16'hC0F1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] writes_issued
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_ADDR, S_DATA, S_DONE, S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [31:0] caddr_q, caddr_d;
  logic [31:0] cdata_q, cdata_d;
  logic        xfer;

  // Status and handshake are pure decodes of the current state.
  assign busy          = (state_q == S_HEADER) || (state_q == S_ADDR) ||
                         (state_q == S_DATA);
  assign in_ready      = busy;
  assign done          = (state_q == S_DONE);
  assign error         = (state_q == S_ERROR);
  assign writes_issued = wcnt_q;
  assign config_addr   = caddr_q;
  assign config_data   = cdata_q;
  assign xfer          = in_valid && in_ready;

  // Next-state logic; the write bus defaults back to its parked value every
  // cycle so a pulse lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    caddr_d = IDLE_ADDR;
    cdata_d = '0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_HEADER;
          wcnt_d  = '0;
        end
      end
      S_HEADER: begin
        if (xfer) begin
          if (in_data[31:16] != MAGIC) begin
            state_d = S_ERROR;
          end else if (in_data[15:0] == 16'd0) begin
            state_d = S_DONE;
          end else begin
            rem_d   = in_data[15:0];
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (xfer) begin
          addr_d  = in_data;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          caddr_d = addr_q;
          cdata_d = in_data;
          // Saturate defensively; with 16-bit N the count cannot exceed 65535.
          wcnt_d  = (wcnt_q == 16'hFFFF) ? wcnt_q : wcnt_q + 16'd1;
          rem_d   = rem_q - 16'd1;
          state_d = (rem_q == 16'd1) ? S_DONE : S_ADDR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset wins over a same-cycle data transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      caddr_q <= IDLE_ADDR;
      cdata_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: expected write pulses are queued when the
// data word is driven and popped when a non-parked bus value appears.
module tb_config_loader;

  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [31:0] in_data;
  logic        in_ready, busy, done, error;
  logic [31:0] config_addr, config_data;
  logic [15:0] writes_issued;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int last_pulse = 0;
  int npulse     = 0;
  logic [63:0] exp_q[$];

  config_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .config_addr(config_addr),
    .config_data(config_data), .busy(busy), .done(done), .error(error),
    .writes_issued(writes_issued)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1ns after the edge and score any write pulse.
  task automatic step();
    logic [63:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (config_addr !== IDLE || config_data !== 32'd0) begin
      npulse++;
      last_pulse = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse_addr", config_addr, IDLE);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_addr", config_addr, e[63:32]);
        chk("pulse_data", config_data, e[31:0]);
      end
    end
  endtask

  // Present one word and hold it until it transfers (bounded wait).
  task automatic send(input logic [31:0] w);
    int n;
    in_data  = w;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int p1;

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    step();
    reset = 1'b0;
    chk("rst_addr", config_addr, IDLE);
    chk("rst_data", config_data, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_wi", {16'd0, writes_issued}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_ready", {31'd0, in_ready}, 32'd0);
    end
    chk("idle_pulses", npulse, 0);

    // Back-to-back stream, two writes.
    do_start();
    chk("busy_hdr", {31'd0, busy}, 32'd1);
    send(32'hC0F1_0002);
    send(32'h0007_0003);
    exp_q.push_back({32'h0007_0003, 32'h0000_00A5});
    send(32'h0000_00A5);
    p1 = last_pulse;
    chk("wi_first", {16'd0, writes_issued}, 32'd1);
    chk("busy_mid", {31'd0, busy}, 32'd1);
    send(32'h0004_0003);
    exp_q.push_back({32'h0004_0003, 32'h0000_0002});
    send(32'h0000_0002);
    chk("pulse_spacing", last_pulse - p1, 2);
    chk("done_on_last", {31'd0, done}, 32'd1);
    chk("busy_on_last", {31'd0, busy}, 32'd0);
    chk("wi_on_last", {16'd0, writes_issued}, 32'd2);
    step();
    chk("pulse_one_cycle_addr", config_addr, IDLE);
    chk("q_empty1", exp_q.size(), 0);

    // Same stream with 3-cycle gaps between address and data words.
    do_start();
    chk("done_cleared", {31'd0, done}, 32'd0);
    chk("wi_cleared", {16'd0, writes_issued}, 32'd0);
    send(32'hC0F1_0002);
    send(32'h0007_0003);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gap_park", config_addr, IDLE);
    end
    exp_q.push_back({32'h0007_0003, 32'h0000_00A5});
    send(32'h0000_00A5);
    chk("gap_pulse_timing", last_pulse, cyc);
    send(32'h0004_0003);
    idle(3);
    exp_q.push_back({32'h0004_0003, 32'h0000_0002});
    send(32'h0000_0002);
    chk("gap_pulse_timing2", last_pulse, cyc);
    chk("gap_done", {31'd0, done}, 32'd1);
    chk("gap_wi", {16'd0, writes_issued}, 32'd2);
    chk("q_empty2", exp_q.size(), 0);

    // Bad header, then recovery.
    p1 = npulse;
    do_start();
    send(32'hBEEF_0001);
    chk("err_flag", {31'd0, error}, 32'd1);
    chk("err_busy", {31'd0, busy}, 32'd0);
    chk("err_ready", {31'd0, in_ready}, 32'd0);
    idle(2);
    chk("err_no_pulse", npulse - p1, 0);
    do_start();
    chk("err_cleared", {31'd0, error}, 32'd0);
    send(32'hC0F1_0001);
    send(32'h0001_0001);
    exp_q.push_back({32'h0001_0001, 32'h1234_5678});
    send(32'h1234_5678);
    chk("rec_done", {31'd0, done}, 32'd1);
    chk("rec_wi", {16'd0, writes_issued}, 32'd1);
    chk("q_empty3", exp_q.size(), 0);

    // Zero-length load.
    p1 = npulse;
    do_start();
    send(32'hC0F1_0000);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_wi", {16'd0, writes_issued}, 32'd0);
    idle(2);
    chk("zero_no_pulse", npulse - p1, 0);

    // start with in_valid in DONE: word not consumed, loader waits in HEADER.
    in_data = 32'hC0F1_0001; in_valid = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("start_valid_busy", {31'd0, busy}, 32'd1);
    send(32'hC0F1_0001);
    send(32'h0002_0002);
    // Ignored start in ADDR... state is DATA now; pulse start there too.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_ignored_busy", {31'd0, busy}, 32'd1);
    chk("start_ignored_wi", {16'd0, writes_issued}, 32'd0);
    // Reset on the cycle the data word is accepted: no pulse follows.
    p1 = npulse;
    in_data = 32'hDEAD_BEEF; in_valid = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    chk("rst_mid_addr", config_addr, IDLE);
    chk("rst_mid_data", config_data, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_wi", {16'd0, writes_issued}, 32'd0);
    idle(2);
    chk("rst_mid_no_pulse", npulse - p1, 0);

    // start during ADDR is ignored.
    do_start();
    send(32'hC0F1_0001);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("addr_start_busy", {31'd0, busy}, 32'd1);
    send(32'h0003_0005);
    exp_q.push_back({32'h0003_0005, 32'h0000_0077});
    send(32'h0000_0077);
    chk("addr_start_done", {31'd0, done}, 32'd1);
    chk("addr_start_wi", {16'd0, writes_issued}, 32'd1);
    chk("q_empty4", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/config_loader.md
# config_loader

Fabric configuration master that issues the write transactions consumed by every tile's config decoder. It accepts a framed configuration stream over a valid/ready word interface and unpacks it into single-cycle `config_addr`/`config_data` write pulses broadcast to the array. Between writes it parks the address bus on a value that no tile decodes, so stray latching is impossible. It sits at the top level between the off-chip bitstream source and the tile grid.

## Interface
- `IDLE_ADDR`, default 32'hFFFF_FFFF: parked address. Upper half 16'hFFFF matches no tile sub-target.
- `MAGIC`, default 16'hC0F1: required header tag in `in_data[31:16]`.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin loading. Honoured only in IDLE, DONE or ERROR.
- `in_data` input 32: stream word.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: loader accepts a word this cycle.
- `config_addr` output 32: registered write address broadcast to tiles. `[31:16]` is the sub-target select, `[15:0]` is the tile id.
- `config_data` output 32: registered write data.
- `busy` output 1: load in progress (HEADER, ADDR or DATA).
- `done` output 1: level; last load completed.
- `error` output 1: level; header tag mismatch.
- `writes_issued` output 16: count of write pulses issued since the last `start`.

## Operation
- Stream frame:
  - Header word: `[31:16]` = MAGIC, `[15:0]` = N (number of writes).
  - Then N pairs, each an address word followed by a data word.
- A transfer occurs on a cycle with `in_valid && in_ready`.
- `in_ready` is a combinational decode of state: 1 in HEADER, ADDR and DATA; 0 otherwise.
- States and transitions:
  - IDLE: on `start`, go to HEADER; clear `done`, `error` and `writes_issued`.
  - HEADER: on transfer, check the tag.
    - Tag ≠ MAGIC: go to ERROR.
    - Tag OK, N = 0: go to DONE.
    - Tag OK, N > 0: load `remaining` = N and go to ADDR.
  - ADDR: on transfer, latch the word into an internal address register and go to DATA.
  - DATA: on transfer, for the next cycle only drive `config_addr` = latched address and `config_data` = the word, increment `writes_issued`, and decrement `remaining`.
    - `remaining` was 1: go to DONE.
    - Otherwise: go to ADDR.
  - DONE: `done` = 1. On `start`, go to HEADER and clear status.
  - ERROR: `error` = 1. On `start`, go to HEADER and clear status.
- `start` in HEADER, ADDR or DATA is ignored.
- Every cycle that is not a write pulse: `config_addr` = IDLE_ADDR and `config_data` = 0.
- The loader does not filter addresses. A stream address equal to IDLE_ADDR is issued as-is.
- `remaining` and `writes_issued` are 16 bits. N = 65535 is legal and `writes_issued` never wraps.

## Timing
- Reset values (the cycle after `reset` is sampled high):
  - state IDLE, `in_ready` 0, `busy` 0, `done` 0, `error` 0, `writes_issued` 0.
  - `config_addr` = IDLE_ADDR, `config_data` = 0.
- Reset mid-load aborts the load. If a data word was accepted on the reset cycle, no write pulse follows it.
- Write pulse: exactly one cycle, in the cycle after the data-word transfer. Tiles latch it on the following rising edge.
- Throughput:
  - Best case is one write every 2 cycles; address and data words arrive back to back.
  - Stalls on `in_valid` = 0 hold state. No pulse is produced during a stall.
- End of a successful load: on the cycle of the final write pulse, `done` rises, `busy` falls and `writes_issued` = N. Final state is DONE.
- Bad header: accepted at cycle T; from T+1, `error` = 1 and `busy` = 0. No write pulse is issued.
- `start` and `in_valid` in the same IDLE cycle: the word is not consumed, because `in_ready` is 0 in IDLE.
- `busy` = 1 exactly while in HEADER, ADDR or DATA.

## Test plan
- Reset, then idle for 10 cycles → `config_addr` = 32'hFFFF_FFFF, `config_data` = 0, `in_ready` = 0 throughout.
- `start`; stream 32'hC0F1_0002, 32'h0007_0003, 32'h0000_00A5, 32'h0004_0003, 32'h0000_0002 with valid held high → exactly two single-cycle pulses, (0x00070003, 0xA5) and (0x00040003, 0x2), 2 cycles apart. `done` = 1 and `writes_issued` = 2 on the second pulse.
- Same stream with `in_valid` dropped for 3 cycles between each address and data word → identical pulses, each issued one cycle after its data transfer. `config_addr` parked during the gaps.
- Header 32'hBEEF_0001 → `error` = 1 the next cycle, no pulse, `in_ready` = 0. A new `start` clears `error` and a valid stream then loads correctly.
- Header 32'hC0F1_0000 → `done` = 1 the next cycle, `writes_issued` = 0, no pulse.
- `reset` asserted on the cycle a data word is accepted → no pulse, all outputs at reset values the next cycle. A `start` pulse issued during ADDR is ignored.
